// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (clk, rst_n, rx -> data_out, data_valid/framing_err pulses, busy)
module uart_rx #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_err,
  output logic       busy
);
  localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT = CYCLES_PER_BIT / 2;
  if (CYCLES_PER_BIT < 4 || CYCLES_PER_BIT > 65535) begin : g_bad_baud
    $error("uart_rx: CYCLES_PER_BIT out of range 4..65535");
  end
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, rx_s_d, tick;
  logic [15:0] baud_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  assign tick = baud_cnt == '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (!rx_s && rx_s_d) ? START : IDLE;
      START:   state_n = tick ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_n = (tick && bit_idx == 3'd7) ? STOP : DATA;
      STOP:    state_n = tick ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {rx_s_d, rx_s, rx_m} <= 3'b111;
      baud_cnt <= '0;
      bit_idx <= '0;
      shift_reg <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      framing_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      {rx_s_d, rx_s, rx_m} <= {rx_s, rx_m, rx};
      busy <= state_n != IDLE;
      data_valid <= state == STOP && tick && rx_s;
      framing_err <= state == STOP && tick && !rx_s;
      baud_cnt <= state == IDLE ? 16'(HALF_BIT - 1) : tick ? 16'(CYCLES_PER_BIT - 1) : baud_cnt - 16'd1;
      if (state == START) bit_idx <= '0;
      else if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (state == DATA && tick) shift_reg[bit_idx] <= rx_s;
      if (state == STOP && tick && rx_s) data_out <= shift_reg;
    end
endmodule
